// File: rtl/nmcu_pkg.sv
// Shared widths and the MAC-array control state encoding.
package nmcu_pkg;

  localparam int DATA_WIDTH = 8;
  localparam int ACC_WIDTH  = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    FLUSH = 2'd2,
    DRAIN = 2'd3
  } pe_mac_state_e;

endpackage

// File: rtl/pe_mac_lane.sv
// One MAC lane: registered full-precision product (stage 1), wrapping
// accumulator (stage 2), and a saturated result snapshot that is captured only
// when a group closes, so the outputs hold between results.
module pe_mac_lane
  import nmcu_pkg::*;
#(
  parameter int DATA_WIDTH = nmcu_pkg::DATA_WIDTH,
  parameter int ACC_WIDTH  = nmcu_pkg::ACC_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  load_en,  // stage 1: capture a*b
  input  logic                  acc_en,   // stage 2: fold product into acc
  input  logic                  acc_clr,  // stage 2: start a new group
  input  logic                  out_en,   // stage 2 of the closing beat
  input  logic [DATA_WIDTH-1:0] a,
  input  logic [DATA_WIDTH-1:0] b,
  output logic [ACC_WIDTH-1:0]  acc,
  output logic [DATA_WIDTH-1:0] result,
  output logic                  sat
);

  localparam int PW = 2 * DATA_WIDTH;
  localparam logic signed [ACC_WIDTH-1:0] MAX_V = ACC_WIDTH'((2 ** (DATA_WIDTH - 1)) - 1);
  localparam logic signed [ACC_WIDTH-1:0] MIN_V = ACC_WIDTH'(-(2 ** (DATA_WIDTH - 1)));

  logic signed [PW-1:0]        a_ext;
  logic signed [PW-1:0]        b_ext;
  logic signed [PW-1:0]        prod_q;
  logic signed [ACC_WIDTH-1:0] prod_ext;
  logic signed [ACC_WIDTH-1:0] acc_q;
  logic signed [ACC_WIDTH-1:0] acc_base;
  logic signed [ACC_WIDTH-1:0] acc_next;
  logic [DATA_WIDTH-1:0]       res_d;
  logic                        sat_d;

  // Operands widened first so the product is exact at 2*DATA_WIDTH bits.
  assign a_ext    = PW'($signed(a));
  assign b_ext    = PW'($signed(b));
  assign prod_ext = ACC_WIDTH'(prod_q);
  assign acc_base = acc_clr ? '0 : acc_q;
  assign acc_next = acc_base + prod_ext;  // wraps modulo 2^ACC_WIDTH

  // Clamp the post-add accumulator into the signed DATA_WIDTH range.
  always_comb begin
    res_d = acc_next[DATA_WIDTH-1:0];
    sat_d = 1'b0;
    if (acc_next > MAX_V) begin
      res_d = MAX_V[DATA_WIDTH-1:0];
      sat_d = 1'b1;
    end else if (acc_next < MIN_V) begin
      res_d = MIN_V[DATA_WIDTH-1:0];
      sat_d = 1'b1;
    end
  end

  // Product, accumulator and output snapshot registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prod_q <= '0;
      acc_q  <= '0;
      acc    <= '0;
      result <= '0;
      sat    <= 1'b0;
    end else begin
      if (load_en) prod_q <= a_ext * b_ext;
      if (acc_en)  acc_q  <= acc_next;
      if (out_en) begin
        acc    <= acc_next;
        result <= res_d;
        sat    <= sat_d;
      end
    end
  end

endmodule

// File: rtl/pe_mac_array.sv
// NUM_LANES parallel signed MAC lanes with grouped accumulation.
//
// Handshake: a beat transfers on a rising edge where in_valid_i && in_ready_o;
// a result transfers on a rising edge where out_valid_o && out_ready_i. While
// out_valid_o is high the result is held stable and no beat is taken.
module pe_mac_array
  import nmcu_pkg::*;
#(
  parameter int DATA_WIDTH = nmcu_pkg::DATA_WIDTH,
  parameter int ACC_WIDTH  = nmcu_pkg::ACC_WIDTH,
  parameter int NUM_LANES  = 4
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            in_valid_i,
  output logic                            in_ready_o,
  input  logic [NUM_LANES*DATA_WIDTH-1:0] a_i,
  input  logic [NUM_LANES*DATA_WIDTH-1:0] b_i,
  input  logic                            first_i,
  input  logic                            last_i,
  output logic                            out_valid_o,
  input  logic                            out_ready_i,
  output logic [NUM_LANES*DATA_WIDTH-1:0] result_o,
  output logic [NUM_LANES*ACC_WIDTH-1:0]  acc_o,
  output logic [NUM_LANES-1:0]            sat_o,
  output logic                            busy_o,
  output pe_mac_state_e                   state_o
);

  pe_mac_state_e state_q;
  logic          accept;
  logic          s2_valid_q;
  logic          s2_first_q;
  logic          s2_last_q;

  // in_ready_o is gated by rst_n so it reads 0 throughout reset.
  assign in_ready_o  = rst_n && ((state_q == IDLE) || (state_q == ACCUM));
  assign accept      = in_valid_i && in_ready_o;
  assign out_valid_o = (state_q == DRAIN);
  assign busy_o      = (state_q != IDLE);
  assign state_o     = state_q;

  // Control FSM plus the stage-2 control pipeline that follows each beat.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      s2_valid_q <= 1'b0;
      s2_first_q <= 1'b0;
      s2_last_q  <= 1'b0;
    end else begin
      s2_valid_q <= accept;
      // A beat arriving in IDLE always opens a fresh group.
      s2_first_q <= accept && (first_i || (state_q == IDLE));
      s2_last_q  <= accept && last_i;
      case (state_q)
        IDLE, ACCUM: if (accept) state_q <= last_i ? FLUSH : ACCUM;
        FLUSH:       state_q <= DRAIN;
        DRAIN:       if (out_ready_i) state_q <= IDLE;
        default:     state_q <= IDLE;
      endcase
    end
  end

  for (genvar n = 0; n < NUM_LANES; n++) begin : g_lane
    pe_mac_lane #(
      .DATA_WIDTH(DATA_WIDTH),
      .ACC_WIDTH (ACC_WIDTH)
    ) u_lane (
      .clk    (clk),
      .rst_n  (rst_n),
      .load_en(accept),
      .acc_en (s2_valid_q),
      .acc_clr(s2_first_q),
      .out_en (s2_valid_q && s2_last_q),
      .a      (a_i[n*DATA_WIDTH +: DATA_WIDTH]),
      .b      (b_i[n*DATA_WIDTH +: DATA_WIDTH]),
      .acc    (acc_o[n*ACC_WIDTH +: ACC_WIDTH]),
      .result (result_o[n*DATA_WIDTH +: DATA_WIDTH]),
      .sat    (sat_o[n])
    );
  end

endmodule

// File: tb/tb_pe_mac_array.sv
// Directed bench for pe_mac_array: a 32-bit-accumulator instance and a
// 16-bit-accumulator instance share all inputs; a monitor pops expected lane
// accumulators from a queue on every result handshake.
module tb_pe_mac_array;
  import nmcu_pkg::*;

  localparam int DW = 8;
  localparam int NL = 4;
  localparam int AW = 32;

  // ---------------- clock / reset ----------------
  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  logic                 in_valid_i  = 1'b0;
  logic                 first_i     = 1'b0;
  logic                 last_i      = 1'b0;
  logic                 out_ready_i = 1'b1;
  logic [NL*DW-1:0]     a_i         = '0;
  logic [NL*DW-1:0]     b_i         = '0;

  logic                 in_ready_o, out_valid_o, busy_o;
  logic [NL*DW-1:0]     result_o;
  logic [NL*AW-1:0]     acc_o;
  logic [NL-1:0]        sat_o;
  pe_mac_state_e        state_o;

  logic                 in_ready_16, out_valid_16, busy_16;
  logic [NL*DW-1:0]     result_16;
  logic [NL*16-1:0]     acc_16;
  logic [NL-1:0]        sat_16;
  pe_mac_state_e        state_16;

  pe_mac_array #(.DATA_WIDTH(DW), .ACC_WIDTH(AW), .NUM_LANES(NL)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
    .a_i(a_i), .b_i(b_i), .first_i(first_i), .last_i(last_i),
    .out_valid_o(out_valid_o), .out_ready_i(out_ready_i), .result_o(result_o),
    .acc_o(acc_o), .sat_o(sat_o), .busy_o(busy_o), .state_o(state_o)
  );

  pe_mac_array #(.DATA_WIDTH(DW), .ACC_WIDTH(16), .NUM_LANES(NL)) dut16 (
    .clk(clk), .rst_n(rst_n), .in_valid_i(in_valid_i), .in_ready_o(in_ready_16),
    .a_i(a_i), .b_i(b_i), .first_i(first_i), .last_i(last_i),
    .out_valid_o(out_valid_16), .out_ready_i(out_ready_i), .result_o(result_16),
    .acc_o(acc_16), .sat_o(sat_16), .busy_o(busy_16), .state_o(state_16)
  );

  // ---------------- scoreboard ----------------
  logic [NL*AW-1:0] exp_q[$];
  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] clamp8(input longint v);
    if (v > 127) return 8'h7f;
    if (v < -128) return 8'h80;
    return v[7:0];
  endfunction

  function automatic logic [NL*DW-1:0] pack4(input int l0, input int l1, input int l2, input int l3);
    return {8'(l3), 8'(l2), 8'(l1), 8'(l0)};
  endfunction

  function automatic logic [NL*AW-1:0] exp4(input int e0, input int e1, input int e2, input int e3);
    return {32'(e3), 32'(e2), 32'(e1), 32'(e0)};
  endfunction

  // Monitor: compare both instances on every result handshake.
  always @(negedge clk) begin
    logic [NL*AW-1:0] e;
    logic [NL*DW-1:0] er, er16;
    logic [NL-1:0]    es, es16;
    logic [NL*16-1:0] ea16;
    longint           v, v16;
    #1;
    if (rst_n && (out_valid_o || out_valid_16)) begin
      check("valid_match16", out_valid_16, out_valid_o);
      if (out_valid_o && out_ready_i) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_result: got acc %0h, expected no result", acc_o);
        end else begin
          e = exp_q.pop_front();
          for (int n = 0; n < NL; n++) begin
            v   = longint'($signed(e[n*32 +: 32]));
            v16 = longint'($signed(e[n*32 +: 16]));
            er[n*8 +: 8]     = clamp8(v);
            es[n]            = (v > 127) || (v < -128);
            ea16[n*16 +: 16] = e[n*32 +: 16];
            er16[n*8 +: 8]   = clamp8(v16);
            es16[n]          = (v16 > 127) || (v16 < -128);
          end
          check("acc", acc_o, e);
          check("result", result_o, er);
          check("sat", sat_o, es);
          check("acc16", acc_16, ea16);
          check("result16", result_16, er16);
          check("sat16", sat_16, es16);
        end
      end
    end
  end

  // ---------------- driver tasks (called at a falling edge) ----------------
  task automatic send_beat(input logic [NL*DW-1:0] a, input logic [NL*DW-1:0] b,
                           input logic first, input logic last);
    int guard;
    a_i = a; b_i = b; first_i = first; last_i = last; in_valid_i = 1'b1;
    guard = 0;
    while (!in_ready_o && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 20) begin
      checks++;
      errors++;
      $display("FAIL beat_accept_timeout: in_ready_o 0, expected 1");
    end
    @(negedge clk);
  endtask

  task automatic go_idle();
    in_valid_i = 1'b0; first_i = 1'b0; last_i = 1'b0; a_i = '0; b_i = '0;
  endtask

  task automatic wait_valid(input string name);
    int g = 0;
    while (!out_valid_o && g < 10) begin
      @(negedge clk);
      g++;
    end
    check(name, out_valid_o, 1'b1);
  endtask

  task automatic wait_done(input string name);
    int g = 0;
    while (exp_q.size() != 0 && g < 40) begin
      @(negedge clk);
      g++;
    end
    check(name, 128'(exp_q.size()), 128'd0);
    @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    time t0;

    // Reset state (asynchronous assertion, before any clock edge).
    #1 rst_n = 1'b0;
    #2;
    check("rst_out_valid", out_valid_o, 1'b0);
    check("rst_in_ready", in_ready_o, 1'b0);
    check("rst_busy", busy_o, 1'b0);
    check("rst_acc", acc_o, '0);
    check("rst_result", result_o, '0);
    check("rst_sat", sat_o, '0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("rst_release_ready", in_ready_o, 1'b1);
    check("rst_release_state", state_o, IDLE);
    @(negedge clk);

    // Single-beat group; out_valid_o appears two cycles after the beat is issued.
    exp_q.push_back(exp4(-12, 30, 56, -200));
    send_beat(pack4(3, 5, -7, -100), pack4(-4, 6, -8, 2), 1'b1, 1'b1);
    go_idle();
    check("lat_issue_plus1", out_valid_o, 1'b0);
    @(negedge clk);
    check("lat_issue_plus2", out_valid_o, 1'b1);
    wait_done("single_done");

    // Saturation with four back-to-back beats (one beat per cycle).
    exp_q.push_back(exp4(64516, -32512, 400, 4));
    t0 = $time;
    for (int i = 0; i < 4; i++)
      send_beat(pack4(127, (i < 2) ? -128 : 0, 10, 1), pack4(127, 127, 10, 1), i == 0, i == 3);
    check("throughput", 128'($time - t0), 128'd40);
    go_idle();
    wait_done("sat_done");

    // Backpressure: result held for 5 cycles, a pending beat is not taken.
    out_ready_i = 1'b0;
    exp_q.push_back(exp4(6, -81, -16256, 0));
    send_beat(pack4(2, -9, 127, 0), pack4(3, 9, -128, 0), 1'b1, 1'b1);
    go_idle();
    wait_valid("bp_valid_rise");
    exp_q.push_back(exp4(1, 0, 0, 0));
    a_i = pack4(1, 0, 0, 0); b_i = pack4(1, 0, 0, 0);
    first_i = 1'b0; last_i = 1'b1; in_valid_i = 1'b1;
    repeat (5) begin
      @(negedge clk);
      check("bp_out_valid", out_valid_o, 1'b1);
      check("bp_in_ready", in_ready_o, 1'b0);
      check("bp_state", state_o, DRAIN);
      check("bp_acc", acc_o, exp4(6, -81, -16256, 0));
      check("bp_result", result_o, pack4(6, -81, -128, 0));
      check("bp_sat", sat_o, 4'b0100);
    end
    out_ready_i = 1'b1;
    @(negedge clk);
    check("bp_idle_state", state_o, IDLE);
    check("bp_idle_ready", in_ready_o, 1'b1);
    @(negedge clk);
    check("bp_next_accepted", state_o, FLUSH);
    go_idle();
    wait_done("bp_done");

    // Restart: first_i mid-group drops the partial sums.
    exp_q.push_back(exp4(25, -12, 0, 0));
    send_beat(pack4(2, 1, 0, 0), pack4(2, 1, 0, 0), 1'b1, 1'b0);
    send_beat(pack4(3, 1, 0, 0), pack4(3, 1, 0, 0), 1'b0, 1'b0);
    send_beat(pack4(5, -3, 0, 0), pack4(5, 4, 0, 0), 1'b1, 1'b1);
    go_idle();
    wait_done("restart_done");

    // Three-beat group with an idle gap after the first beat.
    exp_q.push_back(exp4(-21, 36384, -3, -2500));
    send_beat(pack4(10, 100, -1, 50), pack4(10, 100, 1, -50), 1'b1, 1'b0);
    go_idle();
    check("gap_hold", state_o, ACCUM);
    @(negedge clk);
    send_beat(pack4(-20, 100, -1, 0), pack4(5, 100, 1, 0), 1'b0, 1'b0);
    send_beat(pack4(7, -128, -1, 0), pack4(-3, -128, 1, 0), 1'b0, 1'b1);
    go_idle();
    wait_done("gap_done");

    // Reset mid-group: no result may appear.
    send_beat(pack4(4, 4, 4, 4), pack4(4, 4, 4, 4), 1'b1, 1'b0);
    send_beat(pack4(4, 4, 4, 4), pack4(4, 4, 4, 4), 1'b0, 1'b0);
    go_idle();
    rst_n = 1'b0;
    #1;
    check("midrst_state", state_o, IDLE);
    check("midrst_in_ready", in_ready_o, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (4) begin
      @(negedge clk);
      check("midrst_no_valid", out_valid_o, 1'b0);
    end

    // Reset while a result waits in DRAIN: the result is dropped.
    out_ready_i = 1'b0;
    send_beat(pack4(9, 0, 0, 0), pack4(9, 0, 0, 0), 1'b1, 1'b1);
    go_idle();
    wait_valid("drainrst_valid");
    rst_n = 1'b0;
    #1;
    check("drainrst_out_valid", out_valid_o, 1'b0);
    check("drainrst_acc", acc_o, '0);
    @(negedge clk);
    rst_n = 1'b1;
    out_ready_i = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("drainrst_no_valid", out_valid_o, 1'b0);
    end

    exp_q.push_back(exp4(1, 0, 0, 0));
    send_beat(pack4(1, 0, 0, 0), pack4(1, 0, 0, 0), 1'b1, 1'b1);
    go_idle();
    wait_done("post_reset_done");

    // Wrap: 3 x 127*127 = 48387; a 16-bit accumulator reads -17149 (16'hBD03).
    out_ready_i = 1'b0;
    exp_q.push_back(exp4(48387, 0, 0, 0));
    for (int i = 0; i < 3; i++)
      send_beat(pack4(127, 0, 0, 0), pack4(127, 0, 0, 0), i == 0, i == 2);
    go_idle();
    wait_valid("wrap_valid");
    check("wrap_acc32", acc_o[31:0], 32'd48387);
    check("wrap_acc16", acc_16[15:0], 16'hBD03);
    check("wrap_result16", result_16[7:0], 8'h80);
    check("wrap_sat16", sat_16[0], 1'b1);
    out_ready_i = 1'b1;
    wait_done("wrap_done");

    // ---------------- report ----------------
    repeat (3) @(negedge clk);
    check("final_queue_empty", 128'(exp_q.size()), 128'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
